// File: rtl/soc_system_dpram_arb_pkg.sv
// soc_system_dpram_arb_pkg: shared types and constants for the dual-port RAM arbiter
package soc_system_dpram_arb_pkg;
  typedef enum logic [1:0] {IDLE, LOCKED0, LOCKED1} lock_state_t;
  typedef logic mid_t;
  localparam int ERR_RW_BIT = 0;
  localparam int ERR_LOCK_BIT = 1;
endpackage

// File: rtl/soc_system_dpram_rdpipe.sv
// soc_system_dpram_rdpipe: fixed-latency {valid, id} shift register tracking in-flight reads
module soc_system_dpram_rdpipe
  import soc_system_dpram_arb_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in_valid,
  input  mid_t in_id,
  output logic out_valid,
  output mid_t out_id
);
  logic [DEPTH-1:0] vld;
  mid_t [DEPTH-1:0] id;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld <= '0;
      id <= '0;
    end else begin
      vld[0] <= in_valid;
      id[0] <= in_id;
      for (int k = 1; k < DEPTH; k++) begin
        vld[k] <= vld[k-1];
        id[k] <= id[k-1];
      end
    end
  end
  assign out_valid = vld[DEPTH-1];
  assign out_id = id[DEPTH-1];
endmodule

// File: rtl/soc_system_dpram_arbiter.sv
// soc_system_dpram_arbiter: round-robin, lockable two-master arbiter for one Avalon-MM RAM port
module soc_system_dpram_arbiter
  import soc_system_dpram_arb_pkg::*;
#(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 32,
  parameter int BE_W = 4,
  parameter int READ_LATENCY = 1,
  parameter int LOCK_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  input  logic              m0_lock,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  input  logic              m1_lock,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] ram_address,
  output logic [BE_W-1:0]   ram_byteenable,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic [DATA_W-1:0] ram_writedata,
  input  logic [DATA_W-1:0] ram_readdata,
  output logic [1:0]        err_sticky
);
  lock_state_t state, state_nxt;
  mid_t last_gnt, rsp_id;
  logic [7:0] idle_cnt;
  logic req0, req1, gnt0, gnt1, acc, sel_read, sel_write, sel_lock, rd_acc, timeout, rsp_valid;
  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;
  // A lock pins the grant to its owner; otherwise the master that did not win last goes first.
  assign gnt0 = req0 & (state == LOCKED0 | (state == IDLE & (~req1 | last_gnt)));
  assign gnt1 = req1 & (state == LOCKED1 | (state == IDLE & (~req0 | ~last_gnt)));
  assign acc = gnt0 | gnt1;
  assign sel_read = gnt1 ? m1_read : m0_read;
  assign sel_write = gnt1 ? m1_write : m0_write;
  assign sel_lock = gnt1 ? m1_lock : m0_lock;
  assign rd_acc = acc & sel_read & ~sel_write;
  assign m0_waitrequest = req0 & ~gnt0;
  assign m1_waitrequest = req1 & ~gnt1;
  assign ram_chipselect = acc;
  assign ram_write = acc & sel_write;
  assign ram_address = gnt1 ? m1_address : m0_address;
  assign ram_byteenable = gnt1 ? m1_byteenable : m0_byteenable;
  assign ram_writedata = gnt1 ? m1_writedata : m0_writedata;
  always_comb begin
    state_nxt = state;
    timeout = 1'b0;
    if (state == IDLE)
      state_nxt = (acc & sel_lock) ? (gnt1 ? LOCKED1 : LOCKED0) : IDLE;
    else if (acc)
      state_nxt = sel_lock ? state : IDLE;
    else if (idle_cnt == 8'(LOCK_TIMEOUT - 1)) begin
      state_nxt = IDLE;
      timeout = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      last_gnt <= 1'b1;
      idle_cnt <= '0;
      err_sticky <= '0;
    end else begin
      state <= state_nxt;
      last_gnt <= acc ? gnt1 : last_gnt;
      idle_cnt <= (state == IDLE || acc || timeout) ? 8'd0 : idle_cnt + 8'd1;
      err_sticky[ERR_RW_BIT] <= err_sticky[ERR_RW_BIT] | (acc & sel_read & sel_write);
      err_sticky[ERR_LOCK_BIT] <= err_sticky[ERR_LOCK_BIT] | timeout;
    end
  end
  soc_system_dpram_rdpipe #(.DEPTH(READ_LATENCY)) u_rdpipe (
    .clk(clk),
    .reset_n(reset_n),
    .in_valid(rd_acc),
    .in_id(gnt1),
    .out_valid(rsp_valid),
    .out_id(rsp_id)
  );
  assign m0_readdata = ram_readdata;
  assign m1_readdata = ram_readdata;
  assign m0_readdatavalid = rsp_valid & (rsp_id == 1'b0);
  assign m1_readdatavalid = rsp_valid & (rsp_id == 1'b1);
endmodule

// File: tb/tb_soc_system_dpram_arbiter.sv
// tb_soc_system_dpram_arbiter: directed self-checking bench with a behavioural RAM
module tb_soc_system_dpram_arbiter;
  localparam int RL = 3;
  localparam int LT = 4;
  logic clk = 1'b0;
  logic reset_n;
  logic [1:0] m0_address, m1_address, ram_address;
  logic [3:0] m0_byteenable, m1_byteenable, ram_byteenable;
  logic m0_read, m0_write, m0_lock, m0_waitrequest, m0_readdatavalid;
  logic m1_read, m1_write, m1_lock, m1_waitrequest, m1_readdatavalid;
  logic [31:0] m0_writedata, m1_writedata, m0_readdata, m1_readdata;
  logic ram_chipselect, ram_write;
  logic [31:0] ram_writedata, ram_readdata;
  logic [1:0] err_sticky;
  int tests = 0;
  int fails = 0;
  int n0, n1;
  logic [31:0] mem [4] = '{32'hA0A0_0000, 32'hB1B1_1111, 32'h0000_0000, 32'h3333_3333};
  logic [31:0] rd_pipe [RL];
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (ram_chipselect && ram_write)
      for (int b = 0; b < 4; b++)
        if (ram_byteenable[b]) mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
    rd_pipe[0] <= mem[ram_address];
    for (int k = 1; k < RL; k++) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign ram_readdata = rd_pipe[RL-1];
  soc_system_dpram_arbiter #(.READ_LATENCY(RL), .LOCK_TIMEOUT(LT)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_lock(m0_lock),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_lock(m1_lock),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .ram_address(ram_address), .ram_byteenable(ram_byteenable), .ram_chipselect(ram_chipselect),
    .ram_write(ram_write), .ram_writedata(ram_writedata), .ram_readdata(ram_readdata),
    .err_sticky(err_sticky)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    m0_address = '0; m0_byteenable = 4'hF; m0_read = 0; m0_write = 0; m0_writedata = '0; m0_lock = 0;
    m1_address = '0; m1_byteenable = 4'hF; m1_read = 0; m1_write = 0; m1_writedata = '0; m1_lock = 0;
  endtask
  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask
  initial begin
    idle();
    reset_n = 1'b0;
    tick();
    tick();
    #1;
    chk("rst_err", err_sticky, 0);
    chk("rst_rdv0", m0_readdatavalid, 0);
    chk("rst_rdv1", m1_readdatavalid, 0);
    chk("rst_cs", ram_chipselect, 0);
    chk("rst_ramw", ram_write, 0);
    chk("rst_wait0", m0_waitrequest, 0);
    chk("rst_wait1", m1_waitrequest, 0);
    reset_n = 1'b1;
    tick();
    // single master write then read back
    m0_write = 1; m0_address = 2; m0_writedata = 32'hDEAD_BEEF; m0_byteenable = 4'hF;
    #1;
    chk("t1_wr_wait", m0_waitrequest, 0);
    chk("t1_wr_cs", ram_chipselect, 1);
    chk("t1_wr_ramw", ram_write, 1);
    chk("t1_wr_addr", ram_address, 2);
    tick();
    m0_write = 0; m0_read = 1;
    #1;
    chk("t1_rd_wait", m0_waitrequest, 0);
    chk("t1_rd_ramw", ram_write, 0);
    tick();
    idle();
    for (int c = 1; c <= RL + 1; c++) begin
      #1;
      chk("t1_rdv0", m0_readdatavalid, 32'(c == RL));
      chk("t1_rdv1", m1_readdatavalid, 0);
      if (c == RL) chk("t1_data", m0_readdata, 32'hDEAD_BEEF);
      tick();
    end
    // continuous contention alternates grants, starting with m0 after reset
    do_reset();
    n0 = 0;
    n1 = 0;
    for (int k = 0; k < RL + 6; k++) begin
      if (k < 6) begin
        m0_read = 1; m0_address = 0; m1_read = 1; m1_address = 1;
      end else idle();
      #1;
      if (k < 6) begin
        chk("t2_wait0", m0_waitrequest, 32'(k % 2));
        chk("t2_wait1", m1_waitrequest, 32'(1 - k % 2));
      end
      chk("t2_rdv0", m0_readdatavalid, 32'(k >= RL && (k - RL) % 2 == 0));
      chk("t2_rdv1", m1_readdatavalid, 32'(k >= RL && (k - RL) % 2 == 1));
      if (m0_readdatavalid) begin n0++; chk("t2_data0", m0_readdata, 32'hA0A0_0000); end
      if (m1_readdatavalid) begin n1++; chk("t2_data1", m1_readdata, 32'hB1B1_1111); end
      tick();
    end
    chk("t2_cnt0", n0, 3);
    chk("t2_cnt1", n1, 3);
    // m1 locked read-modify-write holds off m0
    m1_read = 1; m1_address = 3; m1_lock = 1;
    #1;
    chk("t3_lk_wait1", m1_waitrequest, 0);
    tick();
    m1_read = 0; m1_lock = 0; m0_read = 1; m0_address = 0;
    #1;
    chk("t3_b_wait0", m0_waitrequest, 1);
    tick();
    #1;
    chk("t3_c_wait0", m0_waitrequest, 1);
    tick();
    m1_write = 1; m1_address = 3; m1_writedata = 32'h0000_0001;
    #1;
    chk("t3_d_wait0", m0_waitrequest, 1);
    chk("t3_d_wait1", m1_waitrequest, 0);
    chk("t3_d_rdv1", m1_readdatavalid, 1);
    chk("t3_d_data1", m1_readdata, 32'h3333_3333);
    tick();
    m1_write = 0;
    #1;
    chk("t3_e_wait0", m0_waitrequest, 0);
    chk("t3_e_err", err_sticky, 0);
    tick();
    // m0 lock abandoned until the watchdog fires
    m0_lock = 1;
    #1;
    chk("t4_lk_wait0", m0_waitrequest, 0);
    tick();
    m0_read = 0; m0_lock = 0; m1_read = 1; m1_address = 1;
    for (int i = 0; i < LT; i++) begin
      #1;
      chk("t4_held_wait1", m1_waitrequest, 1);
      tick();
    end
    #1;
    chk("t4_rel_wait1", m1_waitrequest, 0);
    chk("t4_rel_addr", ram_address, 1);
    chk("t4_err", err_sticky, 2'b10);
    tick();
    idle();
    // read and write together behaves as a write with no response
    m0_read = 1; m0_write = 1; m0_address = 1; m0_writedata = 32'h1234_5678;
    #1;
    chk("t5_cs", ram_chipselect, 1);
    chk("t5_ramw", ram_write, 1);
    chk("t5_wdata", ram_writedata, 32'h1234_5678);
    tick();
    idle();
    for (int c = 1; c <= RL + 1; c++) begin
      #1;
      chk("t5_rdv0", m0_readdatavalid, 0);
      tick();
    end
    chk("t5_err", err_sticky, 2'b11);
    chk("t5_mem", mem[1], 32'h1234_5678);
    // reset with two reads in flight
    m0_read = 1; m0_address = 0;
    #1;
    chk("t6_wait0", m0_waitrequest, 0);
    tick();
    m0_read = 0; m1_read = 1; m1_address = 1;
    #1;
    chk("t6_wait1", m1_waitrequest, 0);
    tick();
    idle();
    reset_n = 1'b0;
    #1;
    chk("t6_rst_rdv0", m0_readdatavalid, 0);
    chk("t6_rst_rdv1", m1_readdatavalid, 0);
    chk("t6_rst_err", err_sticky, 0);
    tick();
    tick();
    reset_n = 1'b1;
    for (int c = 0; c <= RL; c++) begin
      #1;
      chk("t6_post_rdv0", m0_readdatavalid, 0);
      chk("t6_post_rdv1", m1_readdatavalid, 0);
      chk("t6_post_cs", ram_chipselect, 0);
      chk("t6_post_wait0", m0_waitrequest, 0);
      chk("t6_post_wait1", m1_waitrequest, 0);
      tick();
    end
    m0_read = 1; m1_read = 1;
    #1;
    chk("t6_arb_wait0", m0_waitrequest, 0);
    chk("t6_arb_wait1", m1_waitrequest, 1);
    tick();
    idle();
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/soc_system_dpram_arbiter.md
Name: soc_system_dpram_arbiter

Overview:
- Round-robin arbiter that shares one Avalon-MM port of the 4-word, 32-bit dual-port on-chip RAM between two FPGA-side masters (m0, m1).
- Issues at most one RAM transfer per cycle and tracks in-flight reads through a fixed-latency pipeline, routing each read response only to its owner.
- Supports a lock so one master can perform an atomic read-modify-write, for example a mailbox semaphore. A lock-timeout watchdog releases a lock that is held too long.

Parameters:
- ADDR_W, 2, word address width (RAM depth 4).
- DATA_W, 32, data width.
- BE_W, 4, byteenable width (DATA_W/8).
- READ_LATENCY, 1, cycles from accepted read to valid ram_readdata; legal range 1..4.
- LOCK_TIMEOUT, 16, maximum consecutive idle cycles a lock may be held without a transfer from its owner; legal range 2..255.

Ports:
- clk  in  1  single clock for arbiter and RAM port.
- reset_n  in  1  asynchronous active-low reset.
- m0_address  in  ADDR_W  master 0 word address.
- m0_byteenable  in  BE_W  master 0 byte enables.
- m0_read  in  1  master 0 read request.
- m0_write  in  1  master 0 write request.
- m0_writedata  in  DATA_W  master 0 write data.
- m0_lock  in  1  keep grant after this transfer.
- m0_waitrequest  out  1  command not accepted this cycle.
- m0_readdata  out  DATA_W  read data (ram_readdata broadcast).
- m0_readdatavalid  out  1  m0 read response valid.
- m1_* ports  same set, same widths and meaning, for master 1.
- ram_address  out  ADDR_W  to RAM port address.
- ram_byteenable  out  BE_W  to RAM port byteenable.
- ram_chipselect  out  1  transfer issued this cycle.
- ram_write  out  1  issued transfer is a write.
- ram_writedata  out  DATA_W  to RAM port writedata.
- ram_readdata  in  DATA_W  from RAM port readdata.
- err_sticky  out  2  bit0 = read and write asserted together; bit1 = lock timeout. Cleared only by reset.

Behaviour:
- Request and grant:
  - req_i = mi_read | mi_write.
  - The grant is combinational from req and state; RAM outputs are muxed combinationally from the granted master.
  - ram_chipselect = granted & req.
  - mi_waitrequest = req_i & ~grant_i, so it is low when mi is not requesting.
  - A command is accepted in the cycle req_i=1 and mi_waitrequest=0.
- Round-robin:
  - Register last_gnt resets to 1, so m0 wins the first contention.
  - When both masters request and no lock is held, grant goes to the master other than last_gnt.
  - A lone requester is granted immediately.
  - last_gnt updates on every accepted transfer.
  - Worst-case wait for a continuously requesting master without locks is 1 cycle.
- Lock FSM (states IDLE, LOCKED0, LOCKED1):
  - Reset state is IDLE.
  - IDLE -> LOCKEDi when mi's accepted transfer has mi_lock=1.
  - In LOCKEDi only mi can be granted; the other master sees waitrequest=1.
  - LOCKEDi -> IDLE when mi's accepted transfer has mi_lock=0, or on timeout.
  - An accepted transfer with lock=1 while in LOCKEDi stays in LOCKEDi.
- Timeout:
  - An 8-bit idle counter clears on every accepted owner transfer and increments each cycle in LOCKEDi without one.
  - When it reaches LOCKEDi's limit of LOCK_TIMEOUT, the FSM goes to IDLE, err_sticky[1] is set and the counter clears.
- Read and write together: if mi_read and mi_write are both 1, the transfer is treated as a write, no read response is produced, and err_sticky[0] is set.
- Read response pipeline:
  - A shift register of depth READ_LATENCY carries {valid, id}.
  - Stage 0 is loaded with {accepted read, granted id}.
  - mi_readdatavalid = last_stage.valid & (last_stage.id == i).
  - Exactly one response per accepted read, in issue order, exactly READ_LATENCY cycles after acceptance.
  - Back-to-back reads from alternating masters sustain 1 read per cycle.
- Reset values: last_gnt=1, FSM=IDLE, idle counter=0, pipeline valids=0, err_sticky=0, all readdatavalid=0.
  - Combinational outputs with no requests are ram_chipselect=0, ram_write=0 and waitrequests=0.
- Reset mid-operation: in-flight reads are discarded with no readdatavalid, and an active lock is dropped.
- Data is not modified and there is no width conversion; ram_byteenable passes through from the granted master.

Decomposition:
- Package soc_system_dpram_arb_pkg: lock-state enum (IDLE, LOCKED0, LOCKED1), master-id type (1 bit), constants ERR_RW_BIT=0 and ERR_LOCK_BIT=1.
- One sub-module: soc_system_dpram_rdpipe, the READ_LATENCY-deep {valid, id} shift register with async active-low reset.

Test Plan:
- Write from m0 only (address 2, writedata 0xDEADBEEF, byteenable 0xF), then read from m0 at address 2 -> waitrequest stays 0; m0_readdatavalid is 1 exactly READ_LATENCY cycles after the read; m0_readdata=0xDEADBEEF; m1_readdatavalid stays 0.
- m0 and m1 both issue continuous reads (addresses 0 and 1) for 6 cycles -> grants alternate m0,m1,m0,... starting with m0 after reset; each master gets 3 readdatavalid pulses with the correct data.
- m1 reads address 3 with lock=1, then m0 requests, then m1 writes address 3 with lock=0 -> m0 waitrequest=1 until m1's unlocking write is accepted, and m0 is granted the next cycle.
- m0 locks, then goes idle for LOCK_TIMEOUT cycles while m1 requests -> the lock releases at the limit; m1 is granted the next cycle; err_sticky=2'b10.
- m0 asserts read and write together (address 1, data 0x12345678) -> RAM write occurs; there is no readdatavalid; err_sticky[0]=1.
- Two reads accepted, then reset_n is pulsed low before their responses -> no readdatavalid pulses; after release, all outputs are at reset values and the next contention grants m0 first.
